// File: rtl/bus_uart_if.sv
// Bus port of bus_uart: the core's single-cycle memory protocol with registered read data.
interface bus_uart_if;
    logic        enable;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wvalue;
    logic [31:0] rvalue;

    modport master (output enable, wstrb, addr, wvalue, input rvalue);
    modport slave  (input enable, wstrb, addr, wvalue, output rvalue);
endinterface

// File: rtl/bus_uart.sv
// Memory-mapped 8N1 UART: TX FIFO plus bit-serial transmitter, optional single-byte receiver.
// Define BUS_UART_RX_EN to build the receiver; otherwise uart_rx_i is ignored.
module bus_uart #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned DEFAULT_DIV = 217
) (
    input  logic        clk_i,
    input  logic        rst_i,
    bus_uart_if.slave   bus,
    output logic        uart_tx_o,
    input  logic        uart_rx_i
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DepthCnt = (PW + 1)'(FIFO_DEPTH);
    localparam logic [15:0] DivReset = 16'(DEFAULT_DIV);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    logic        rd, wr, data_rd, push_req, push, pop, ovf_set, status_wr;
    logic [1:0]  sel;
    logic [15:0] div_q;
    logic [31:0] rvalue_q, rdata, status;
    logic        tx_overflow_q;

    logic [7:0]  fifo_q [FIFO_DEPTH];
    logic [PW:0] wptr_q, rptr_q, fifo_count;
    logic        fifo_empty, fifo_full;

    logic [1:0]  tx_state_q;
    logic [15:0] tx_cnt_q, tx_div_q;
    logic [2:0]  tx_bit_q;
    logic [7:0]  tx_shift_q;
    logic        tx_q, tx_tick;

    logic        rx_valid, rx_overrun, rx_frame_err;
    logic [7:0]  rx_data;

    assign sel        = bus.addr[3:2];
    assign rd         = bus.enable && (bus.wstrb == 4'b0000);
    assign wr         = bus.enable && (bus.wstrb != 4'b0000);
    assign data_rd    = rd && (sel == 2'd0);
    assign status_wr  = wr && (sel == 2'd1) && bus.wstrb[0];
    assign push_req   = wr && (sel == 2'd0) && bus.wstrb[0];
    assign fifo_count = wptr_q - rptr_q;
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == DepthCnt);
    // Fullness is taken from registered pointers, so a same-cycle pop cannot make room.
    assign push       = push_req && !fifo_full;
    assign ovf_set    = push_req && fifo_full;
    assign tx_tick    = (tx_cnt_q == 16'd1);
    assign pop        = !fifo_empty &&
                        ((tx_state_q == StIdle) || ((tx_state_q == StStop) && tx_tick));

    assign uart_tx_o  = tx_q;
    assign bus.rvalue = rvalue_q;

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wptr_q[PW-1:0]] <= bus.wvalue[7:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            div_q         <= DivReset;
            tx_overflow_q <= 1'b0;
            rvalue_q      <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            if (wr && (sel == 2'd2) && (bus.wstrb[1:0] == 2'b11)) begin
                div_q <= (bus.wvalue[15:0] < 16'd4) ? 16'd4 : bus.wvalue[15:0];
            end
            tx_overflow_q <= ovf_set | (tx_overflow_q & ~(status_wr & bus.wvalue[6]));
            if (rd) rvalue_q <= rdata;
        end
    end

    // Divider is captured per frame so a mid-frame DIVIDER write only affects the next frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_state_q <= StIdle;
            tx_cnt_q   <= '0;
            tx_div_q   <= DivReset;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else if (pop) begin
            tx_state_q <= StStart;
            tx_cnt_q   <= div_q;
            tx_div_q   <= div_q;
            tx_shift_q <= fifo_q[rptr_q[PW-1:0]];
            tx_q       <= 1'b0;
        end else if (tx_state_q != StIdle) begin
            if (!tx_tick) begin
                tx_cnt_q <= tx_cnt_q - 16'd1;
            end else begin
                tx_cnt_q <= tx_div_q;
                case (tx_state_q)
                    StStart: begin
                        tx_state_q <= StData;
                        tx_bit_q   <= '0;
                        tx_q       <= tx_shift_q[0];
                    end
                    StData: begin
                        if (tx_bit_q == 3'd7) begin
                            tx_state_q <= StStop;
                            tx_q       <= 1'b1;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 3'd1;
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_q       <= tx_shift_q[1];
                        end
                    end
                    default: tx_state_q <= StIdle;
                endcase
            end
        end
    end

`ifdef BUS_UART_RX_EN
    logic [2:0]  rx_sync_q;
    logic [1:0]  rx_state_q;
    logic [15:0] rx_cnt_q, rx_div_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_shift_q, rx_data_q;
    logic        rx_valid_q, rx_overrun_q, rx_frame_err_q;
    logic        rx_s, rx_tick, rx_done, rx_ferr;

    // rx_sync_q[1] is the synchronised line; rx_sync_q[2] is its previous value for edge detect.
    assign rx_s         = rx_sync_q[1];
    assign rx_tick      = (rx_cnt_q == 16'd1);
    assign rx_done      = (rx_state_q == StStop) && rx_tick && rx_s;
    assign rx_ferr      = (rx_state_q == StStop) && rx_tick && !rx_s;
    assign rx_valid     = rx_valid_q;
    assign rx_overrun   = rx_overrun_q;
    assign rx_frame_err = rx_frame_err_q;
    assign rx_data      = rx_data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_sync_q      <= 3'b111;
            rx_state_q     <= StIdle;
            rx_cnt_q       <= '0;
            rx_div_q       <= DivReset;
            rx_bit_q       <= '0;
            rx_shift_q     <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_overrun_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
        end else begin
            rx_sync_q <= {rx_sync_q[1:0], uart_rx_i};
            case (rx_state_q)
                StIdle: begin
                    if (rx_sync_q[2] && !rx_s) begin
                        rx_state_q <= StStart;
                        rx_cnt_q   <= {1'b0, div_q[15:1]};
                        rx_div_q   <= div_q;
                    end
                end
                StStart: begin
                    if (!rx_tick) begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end else if (rx_s) begin
                        rx_state_q <= StIdle;
                    end else begin
                        rx_state_q <= StData;
                        rx_cnt_q   <= rx_div_q;
                        rx_bit_q   <= '0;
                    end
                end
                StData: begin
                    if (!rx_tick) begin
                        rx_cnt_q <= rx_cnt_q - 16'd1;
                    end else begin
                        rx_shift_q <= {rx_s, rx_shift_q[7:1]};
                        rx_cnt_q   <= rx_div_q;
                        rx_bit_q   <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_q <= StStop;
                    end
                end
                default: begin
                    if (!rx_tick) rx_cnt_q <= rx_cnt_q - 16'd1;
                    else          rx_state_q <= StIdle;
                end
            endcase
            // A completing byte beats a same-cycle DATA read; the read still returns the old byte.
            if (rx_done) begin
                rx_data_q  <= rx_shift_q;
                rx_valid_q <= 1'b1;
            end else if (data_rd) begin
                rx_valid_q <= 1'b0;
            end
            rx_overrun_q   <= (rx_done & rx_valid_q) |
                              (rx_overrun_q & ~(status_wr & bus.wvalue[4]));
            rx_frame_err_q <= rx_ferr | (rx_frame_err_q & ~(status_wr & bus.wvalue[5]));
        end
    end
`else
    logic unused_rx;
    assign unused_rx    = uart_rx_i;
    assign rx_valid     = 1'b0;
    assign rx_overrun   = 1'b0;
    assign rx_frame_err = 1'b0;
    assign rx_data      = 8'h00;
`endif

    logic unused_bus;
    assign unused_bus = ^{bus.addr[31:4], bus.addr[1:0], bus.wvalue[31:16]};

    always_comb begin
        status       = '0;
        status[0]    = fifo_empty;
        status[1]    = fifo_full;
        status[2]    = (tx_state_q != StIdle);
        status[3]    = rx_valid;
        status[4]    = rx_overrun;
        status[5]    = rx_frame_err;
        status[6]    = tx_overflow_q;
        status[12:8] = 5'(fifo_count);
        case (sel)
            2'd0:    rdata = {24'b0, rx_data};
            2'd1:    rdata = status;
            2'd2:    rdata = {16'b0, div_q};
            default: rdata = '0;
        endcase
    end
endmodule

// File: tb/tb_bus_uart.sv
// Randomised self-checking bench for bus_uart; TX frames are decoded by a line-level monitor.
module tb_bus_uart;
    logic clk = 1'b0;
    logic rst;
    logic uart_tx;
    logic uart_rx;

    bus_uart_if bus_if ();

    bus_uart #(
        .FIFO_DEPTH  (16),
        .DEFAULT_DIV (217)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus_if),
        .uart_tx_o (uart_tx),
        .uart_rx_i (uart_rx)
    );

    always #5 clk = ~clk;

`ifdef BUS_UART_RX_EN
    localparam logic RxEn = 1'b1;
`else
    localparam logic RxEn = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    bit mon_en  = 1'b0;
    int mon_div = 8;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_access(input logic [1:0] reg_idx, input logic [31:0] data,
                              input logic [3:0] strb);
        logic [31:0] a;
        a = $urandom;
        a[3:2] = reg_idx;
        @(negedge clk);
        bus_if.enable = 1'b1;
        bus_if.wstrb  = strb;
        bus_if.addr   = a;
        bus_if.wvalue = data;
        @(negedge clk);
        bus_if.enable = 1'b0;
        bus_if.wstrb  = 4'b0000;
    endtask

    task automatic bus_write(input logic [1:0] reg_idx, input logic [31:0] data,
                             input logic [3:0] strb);
        bus_access(reg_idx, data, strb);
    endtask

    task automatic bus_read(input logic [1:0] reg_idx, output logic [31:0] data);
        bus_access(reg_idx, $urandom, 4'b0000);
        data = bus_if.rvalue;
    endtask

    task automatic wait_idle();
        logic [31:0] st;
        bit done;
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            bus_read(2'd1, st);
            if (!st[2] && st[0]) done = 1'b1;
        end
        check("tx_drain_in_budget", {31'b0, done}, 32'd1);
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop, input int d);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (d) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (d) @(negedge clk);
    endtask

    // Decodes frames from the line at mid-bit and compares against the queue of pushed bytes.
    always begin
        logic [7:0] rb;
        int d;
        @(negedge uart_tx);
        if (mon_en) begin
            d = mon_div;
            repeat (d / 2) @(negedge clk);
            check("tx_start_bit", {31'b0, uart_tx}, 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (d) @(negedge clk);
                rb[i] = uart_tx;
            end
            repeat (d) @(negedge clk);
            check("tx_stop_bit", {31'b0, uart_tx}, 32'd1);
            check("tx_frame_expected", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) check("tx_byte", {24'b0, rb}, {24'b0, exp_q.pop_front()});
        end
    end

    initial begin
        logic [31:0] got;
        logic [31:0] exp_st;
        logic [9:0]  frame;
        logic [7:0]  b, b1, b2, b3;
        int d, n;

        rst = 1'b1;
        uart_rx = 1'b1;
        bus_if.enable = 1'b0;
        bus_if.wstrb  = 4'b0000;
        bus_if.addr   = '0;
        bus_if.wvalue = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("reset_rvalue", bus_if.rvalue, 32'd0);
        check("reset_tx_idle", {31'b0, uart_tx}, 32'd1);
        bus_read(2'd1, got);
        check("reset_status", got, 32'h1);
        bus_read(2'd2, got);
        check("reset_div", got, 32'd217);
        bus_write(2'd0, 32'h0000_0055, 4'b0010);
        check("rvalue_hold_on_write", bus_if.rvalue, 32'd217);
        bus_read(2'd1, got);
        check("no_push_without_strb0", got, 32'h1);
        bus_write(2'd2, 32'd9, 4'b0001);
        bus_read(2'd2, got);
        check("div_needs_both_strobes", got, 32'd217);

        // Exact waveform of one frame at div 8.
        bus_write(2'd2, 32'd8, 4'b0011);
        frame = {1'b1, 8'hA5, 1'b0};
        bus_write(2'd0, 32'h0000_00A5, 4'b0001);
        for (int k = 1; k <= 81; k++) begin
            @(negedge clk);
            check("tx_a5_wave", {31'b0, uart_tx}, (k <= 80) ? {31'b0, frame[(k - 1) / 8]} : 32'd1);
        end
        bus_read(2'd1, got);
        check("tx_busy_cleared", got, 32'h1);

        // Random bursts at random dividers (clamped to 4).
        mon_en = 1'b1;
        for (int it = 0; it < 4; it++) begin
            d = $urandom_range(0, 12);
            bus_write(2'd2, d, 4'b0011);
            mon_div = (d < 4) ? 4 : d;
            bus_read(2'd2, got);
            check("div_readback", got, mon_div);
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                bus_write(2'd0, {24'($urandom), b}, 4'b0001);
            end
            wait_idle();
            check("tx_all_bytes_sent", exp_q.size(), 32'd0);
        end
        mon_en = 1'b0;

        // Overflow with transmitter stalled in a long frame.
        bus_write(2'd2, 32'd2, 4'b0011);
        bus_read(2'd2, got);
        check("div_clamp_2", got, 32'd4);
        bus_write(2'd2, 32'd1000, 4'b0011);
        bus_write(2'd0, 32'h11, 4'b0001);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 17; k++) bus_write(2'd0, $urandom, 4'b0001);
        bus_read(2'd1, got);
        exp_st = (32'd16 << 8) | (32'd1 << 6) | (32'd1 << 2) | (32'd1 << 1);
        check("status_full_overflow", got, exp_st);
        bus_write(2'd1, 32'h40, 4'b0001);
        bus_read(2'd1, got);
        check("status_after_w1c", got, exp_st & ~32'h40);

        // Asynchronous reset in the middle of the start bit.
        check("tx_low_midframe", {31'b0, uart_tx}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("tx_async_reset", {31'b0, uart_tx}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        bus_read(2'd1, got);
        check("status_after_reset", got, 32'h1);
        bus_read(2'd2, got);
        check("div_after_reset", got, 32'd217);
        bus_read(2'd0, got);
        check("rx_data_after_reset", got, 32'd0);
        bus_read(2'd3, got);
        check("reserved_reads_zero", got, 32'd0);

        // Receiver at div 16.
        bus_write(2'd2, 32'd16, 4'b0011);
        rx_send(8'h3C, 1'b1, 16);
        bus_read(2'd1, got);
        check("rx_valid_set", got, 32'h1 | {28'b0, RxEn, 3'b0});
        bus_read(2'd0, got);
        check("rx_data_3c", got, RxEn ? 32'h3C : 32'h0);
        bus_read(2'd1, got);
        check("rx_valid_cleared", got, 32'h1);

        b1 = 8'($urandom);
        b2 = 8'($urandom);
        b3 = b2 ^ 8'hFF;
        rx_send(b1, 1'b1, 16);
        rx_send(b2, 1'b1, 16);
        bus_read(2'd1, got);
        check("rx_overrun", got, 32'h1 | (RxEn ? 32'h18 : 32'h0));
        bus_read(2'd0, got);
        check("rx_data_overwritten", got, RxEn ? {24'b0, b2} : 32'h0);

        rx_send(b3, 1'b0, 16);
        bus_read(2'd1, got);
        check("rx_frame_err", got, 32'h1 | (RxEn ? 32'h30 : 32'h0));
        bus_read(2'd0, got);
        check("rx_data_kept_on_ferr", got, RxEn ? {24'b0, b2} : 32'h0);
        bus_write(2'd1, 32'h30, 4'b0001);
        bus_read(2'd1, got);
        check("rx_flags_w1c", got, 32'h1);

        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        bus_read(2'd1, got);
        check("rx_glitch_ignored", got, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_uart.md
# bus_uart

Memory-mapped 8N1 UART peripheral on the CPU data bus, downstream of the core's `enable`/`wstrb`/`addr`/`wvalue`/`rvalue` port.

- Transmit path: a TX FIFO drained by a bit-serial transmitter.
- Receive path: an optional single-byte receiver.
- Bus model: same single-cycle, registered-read protocol the core expects from memory.
- An external address decoder gates `enable_i`; this block decodes only `addr_i[3:2]`.

## Interface
- `FIFO_DEPTH`, 16: TX FIFO entries; power of two, ≥2.
- `DEFAULT_DIV`, 217: reset value of the clocks-per-bit divider (25 MHz / 115200).

- `clk_i`  in  1  clock; all state on rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `enable_i`  in  1  bus access this cycle.
- `wstrb_i`  in  4  byte write strobes; 0 with `enable_i` means read.
- `addr_i`  in  32  byte address; only `[3:2]` decoded.
- `wvalue_i`  in  32  write data.
- `rvalue_o`  out  32  registered read data.
- `uart_tx_o`  out  1  serial out; idles high.
- `uart_rx_i`  in  1  serial in; asynchronous to `clk_i`.

## Operation
- Register map, selected by `addr_i[3:2]`:
  - 0 DATA
    - Write with `wstrb_i[0]`: push `wvalue_i[7:0]` to the TX FIFO.
    - Read: returns `{24'b0, rx_data}` and clears `rx_valid`.
  - 1 STATUS
    - Bits: [0] fifo_empty, [1] fifo_full, [2] tx_busy (FSM ≠ IDLE), [3] rx_valid, [4] rx_overrun, [5] rx_frame_err, [6] tx_overflow, [12:8] fifo_count, others 0.
    - Write with `wstrb_i[0]`: write-1-to-clear of bits [6:4].
  - 2 DIVIDER
    - Written only when `wstrb_i[1:0]==2'b11`: `div <= max(wvalue_i[15:0], 4)`.
    - Read: `{16'b0, div}`.
  - 3 reserved: reads 0, writes ignored.
- Read data: `rvalue_o` updates only on a read (`enable_i && wstrb_i==0`) and holds its value otherwise.
- TX push to a full FIFO: the byte is dropped and `tx_overflow` is set. Fullness is judged at the start of the cycle, so a same-cycle pop does not rescue the push.
- TX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE with FIFO non-empty: pop the FIFO, latch `div` into the bit counter, go to START.
  - Each state or bit lasts exactly `div` clocks.
  - Bits are sent LSB first, 8 data bits.
  - After STOP: go to START if the FIFO is non-empty, otherwise IDLE. Back-to-back frames have no idle gap.
  - A DIVIDER write during a frame takes effect at the next frame.
- RX:
  - Input passes through a 2-flop synchroniser.
  - IDLE: a high→low transition starts reception.
  - At `div/2` the start bit is rechecked; if it is high, this is a false start and the receiver returns to IDLE.
  - Then 8 samples taken every `div` clocks, then the stop sample.
  - Stop bit high: `rx_data` <= byte, `rx_valid` <= 1. If `rx_valid` was already 1, the new byte overwrites and `rx_overrun` is set.
  - Stop bit low: the byte is discarded and `rx_frame_err` is set.
  - A DATA read and a new byte completing in the same cycle: the new byte wins and `rx_valid` stays 1; the read returns the old byte.
- Sticky bits: a W1C and a set in the same cycle leaves the bit set.

## Timing
- Reset values: `rvalue_o`=0, `uart_tx_o`=1, FIFO empty, TX/RX FSMs IDLE, `div`=`DEFAULT_DIV`, `rx_data`=0, all status flags 0.
- Reset is asynchronous and mid-frame: `uart_tx_o` goes high immediately and the frame is abandoned.
- Read latency is 1 cycle: `rvalue_o` is valid in the cycle after the `enable_i` cycle, matching the core's fetch and load timing.
- Writes take effect on the same edge as the `enable_i` cycle.
- TX latency:
  - DATA write accepted at edge N (idle, FIFO empty).
  - Pop and START at edge N+1, so `uart_tx_o` is low from edge N+1.
  - Frame length is 10·`div` clocks.
- FIFO:
  - Count range is 0..`FIFO_DEPTH`.
  - Pointers are log2(`FIFO_DEPTH`)+1 bits wide and wrap naturally.
  - Simultaneous push and pop when non-full leaves the count unchanged.
  - Push into an empty FIFO while IDLE: the pop happens next cycle, never the same cycle.

## Configuration
- `BUS_UART_RX_EN`
  - Defined: the receiver, synchroniser, and `rx_*` state are built.
  - Undefined: no RX logic is built and `uart_rx_i` is unused. STATUS bits [5:3] read 0, DATA reads return 0, and W1C of bits [5:4] has no effect.

## Test plan
- Reset, then read STATUS → `rvalue_o`=0x00000001 next cycle; `uart_tx_o`=1; read DIVIDER → 217.
- Write DIVIDER=8, then DATA=0xA5 → `uart_tx_o`: low for 8 clocks from the edge after the write, then bits 1,0,1,0,0,1,0,1 at 8 clocks each, then high for 8; `tx_busy` returns to 0.
- Write DIVIDER=2 → reads back 4. Then push 17 bytes with the FIFO full at 16 and the TX stalled mid-frame → `tx_overflow`=1, fifo_count=16. Write STATUS=0x40 → `tx_overflow`=0.
- Assert `rst_i` mid-frame, asynchronously between edges → `uart_tx_o`=1 before the next edge; STATUS reads 0x00000001.
- With `BUS_UART_RX_EN`, drive frame 0x3C at `div`=16 → `rx_valid`=1 and DATA read returns 0x3C. A second frame sent without reading → `rx_overrun`=1. A frame with stop bit low → `rx_frame_err`=1 and `rx_data` unchanged. A 4-clock low glitch → ignored.
- Without `BUS_UART_RX_EN`, drive the same frames → STATUS [5:3]=0 and DATA reads 0.
